// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver
//   Priority resolver stage of an 8237A-style DMA controller. Qualifies the
//   raw channel DREQ lines with mask, software-request and polarity settings,
//   arbitrates with fixed or rotating priority, and presents one winning
//   request on VALID_DREQ0..3. It then sequences DACK and the rotation
//   pointer from the hrq/validDACK handshake with timing-and-control.
//
//   Ports
//     CLK, RESET        clock, synchronous active-high reset
//     DREQ[3:0]         raw channel requests (active low when dreqSenseLow=1)
//     maskReg[3:0]      1 blocks the hardware DREQ of that channel
//     swReq[3:0]        software requests, not masked
//     ctrlDisable       1 blocks all requests
//     rotPriority       0 fixed priority (ch0 highest), 1 rotating
//     dreqSenseLow      DREQ polarity
//     dackSenseHigh     DACK polarity
//     hrq, validDACK    handshake from timing-and-control
//     VALID_DREQ0..3    one-hot winning request
//     DACK[3:0]         channel acknowledges, polarity per dackSenseHigh
//     activeCh[1:0]     granted channel
//     busy              FSM not idle
//     swReqClr[3:0]     one-cycle pulse clearing the serviced software request
//
//   Optional build macro DMA_DREQ_SYNC_EN: adds a 2-flop synchronizer on
//   each DREQ bit (2 extra cycles of DREQ-to-VALID_DREQ latency).

module dma_priority_resolver #(
  parameter int unsigned NUM_CH = 4  // only 4 is supported
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swReq,
  input  logic              ctrlDisable,
  input  logic              rotPriority,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
  input  logic              hrq,
  input  logic              validDACK,
  output logic              VALID_DREQ0,
  output logic              VALID_DREQ1,
  output logic              VALID_DREQ2,
  output logic              VALID_DREQ3,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        activeCh,
  output logic              busy,
  output logic [NUM_CH-1:0] swReqClr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_SERV,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        top_ch_q, top_ch_d;
  logic [NUM_CH-1:0] valid_dreq_q, valid_dreq_d;
  logic [NUM_CH-1:0] dack_active_q, dack_active_d;
  logic [1:0]        active_ch_q, active_ch_d;
  logic [NUM_CH-1:0] sw_req_clr_q, sw_req_clr_d;

  logic [NUM_CH-1:0] dreq_eff;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] act_onehot;
  logic [1:0]        ptr;
  logic [1:0]        idx;
  logic [1:0]        win_ch;
  logic              win_found;

`ifdef DMA_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreq_meta_q, dreq_sync_q;

  // Reset to the inactive DREQ level so no request is seen out of reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_meta_q <= {NUM_CH{dreqSenseLow}};
      dreq_sync_q <= {NUM_CH{dreqSenseLow}};
    end else begin
      dreq_meta_q <= DREQ;
      dreq_sync_q <= dreq_meta_q;
    end
  end

  assign dreq_eff = dreq_sync_q;
`else
  assign dreq_eff = DREQ;
`endif

  assign req = {NUM_CH{~ctrlDisable}} &
               (((dreq_eff ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | swReq);

  assign act_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << active_ch_q;

  // First set request scanning upward from the pointer, wrapping mod 4.
  always_comb begin
    ptr       = rotPriority ? top_ch_q : '0;
    idx       = '0;
    win_ch    = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    top_ch_d      = rotPriority ? top_ch_q : '0;
    valid_dreq_d  = valid_dreq_q;
    dack_active_d = dack_active_q;
    active_ch_d   = active_ch_q;
    sw_req_clr_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          valid_dreq_d = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch;
          active_ch_d  = win_ch;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (validDACK) begin
          dack_active_d = act_onehot;
          state_d       = ST_SERV;
        end else if (!req[active_ch_q] && !hrq) begin
          valid_dreq_d = '0;
          state_d      = ST_IDLE;
        end
      end
      ST_SERV: begin
        // DONE's clears, pointer update and swReqClr pulse are registered on
        // entry so they are visible for exactly the one DONE cycle.
        if (!validDACK) begin
          valid_dreq_d  = '0;
          dack_active_d = '0;
          if (swReq[active_ch_q]) sw_req_clr_d = act_onehot;
          if (rotPriority) top_ch_d = active_ch_q + 2'd1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      top_ch_q      <= '0;
      valid_dreq_q  <= '0;
      dack_active_q <= '0;
      active_ch_q   <= '0;
      sw_req_clr_q  <= '0;
    end else begin
      state_q       <= state_d;
      top_ch_q      <= top_ch_d;
      valid_dreq_q  <= valid_dreq_d;
      dack_active_q <= dack_active_d;
      active_ch_q   <= active_ch_d;
      sw_req_clr_q  <= sw_req_clr_d;
    end
  end

  assign VALID_DREQ0 = valid_dreq_q[0];
  assign VALID_DREQ1 = valid_dreq_q[1];
  assign VALID_DREQ2 = valid_dreq_q[2];
  assign VALID_DREQ3 = valid_dreq_q[3];
  assign DACK        = dackSenseHigh ? dack_active_q : ~dack_active_q;
  assign activeCh    = active_ch_q;
  assign busy        = (state_q != ST_IDLE);
  assign swReqClr    = sw_req_clr_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: directed scenarios from the
// test plan plus a randomized arbitration run against a reference model that
// works from the request qualification formula and modular pointer distance.
`timescale 1ns/1ps

module tb_dma_priority_resolver;

`ifdef DMA_DREQ_SYNC_EN
  localparam int XLAT = 2;
`else
  localparam int XLAT = 0;
`endif

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ, maskReg, swReq;
  logic       ctrlDisable, rotPriority, dreqSenseLow, dackSenseHigh;
  logic       hrq, validDACK;
  logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       busy;
  logic [3:0] swReqClr;
  logic [3:0] valid_vec;

  int checks = 0;
  int errors = 0;
  int model_top = 0;

  assign valid_vec = {VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};

  dma_priority_resolver #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg), .swReq(swReq),
    .ctrlDisable(ctrlDisable), .rotPriority(rotPriority),
    .dreqSenseLow(dreqSenseLow), .dackSenseHigh(dackSenseHigh),
    .hrq(hrq), .validDACK(validDACK),
    .VALID_DREQ0(VALID_DREQ0), .VALID_DREQ1(VALID_DREQ1),
    .VALID_DREQ2(VALID_DREQ2), .VALID_DREQ3(VALID_DREQ3),
    .DACK(DACK), .activeCh(activeCh), .busy(busy), .swReqClr(swReqClr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Outputs are sampled and inputs driven 1ns after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_grant(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (valid_vec != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (valid_vec != 4'b0000) ok = 1'b1;
  endtask

  // Return to idle with no requests; the disable window lets the DREQ path settle.
  task automatic go_quiet();
    ctrlDisable = 1'b1;
    DREQ        = {4{dreqSenseLow}};
    swReq       = 4'b0000;
    validDACK   = 1'b0;
    hrq         = 1'b0;
    step(6 + XLAT);
    ctrlDisable = 1'b0;
  endtask

  // A channel requests when its DREQ is at the active level and unmasked,
  // or when its software request bit is set; ctrlDisable vetoes everything.
  function automatic logic [3:0] model_req(input logic [3:0] dreq, input logic [3:0] mask,
                                           input logic [3:0] sw, input logic dis,
                                           input logic sense_low);
    logic [3:0] r;
    r = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      bit hw_active;
      hw_active = sense_low ? (dreq[c] == 1'b0) : (dreq[c] == 1'b1);
      if (!dis && ((hw_active && !mask[c]) || sw[c])) r[c] = 1'b1;
    end
    return r;
  endfunction

  // Winner is the requesting channel nearest to the pointer going upward mod 4.
  function automatic int model_winner(input logic [3:0] r, input int top);
    int best, bestd;
    best  = -1;
    bestd = 99;
    for (int c = 0; c < 4; c++) begin
      if (r[c] && ((c - top + 4) % 4) < bestd) begin
        bestd = (c - top + 4) % 4;
        best  = c;
      end
    end
    return best;
  endfunction

  task automatic test_reset();
    RESET = 1'b1; DREQ = 4'b0000; maskReg = 4'b0000; swReq = 4'b0000;
    ctrlDisable = 1'b0; rotPriority = 1'b0; dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b0; hrq = 1'b0; validDACK = 1'b0;
    step(3);
    checks++; if (valid_vec !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected %b", valid_vec, 4'b0000); end
    checks++; if (DACK !== 4'hF) begin errors++; $display("FAIL reset_dack: got %h expected %h", DACK, 4'hF); end
    checks++; if (activeCh !== 2'd0) begin errors++; $display("FAIL reset_activech: got %0d expected 0", activeCh); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (swReqClr !== 4'b0000) begin errors++; $display("FAIL reset_swreqclr: got %b expected 0000", swReqClr); end
    RESET = 1'b0;
    step(1);
  endtask

  task automatic test_fixed_priority();
    rotPriority = 1'b0;
    DREQ = 4'b1010;
    step(1 + XLAT);
    checks++; if (valid_vec !== 4'b0010) begin errors++; $display("FAIL fixed_grant: got %b expected %b", valid_vec, 4'b0010); end
    checks++; if (activeCh !== 2'd1) begin errors++; $display("FAIL fixed_activech: got %0d expected 1", activeCh); end
    validDACK = 1'b1;
    step(1);
    checks++; if (DACK !== 4'b1101) begin errors++; $display("FAIL fixed_dack: got %b expected %b", DACK, 4'b1101); end
    DREQ = 4'b1000;
    step(2);
    checks++; if (DACK !== 4'b1101 || valid_vec !== 4'b0010) begin errors++; $display("FAIL fixed_serv_hold: got dack=%b valid=%b expected dack=1101 valid=0010", DACK, valid_vec); end
    validDACK = 1'b0;
    step(1);
    checks++; if (valid_vec !== 4'b0000 || DACK !== 4'hF || busy !== 1'b1) begin errors++; $display("FAIL fixed_done: got valid=%b dack=%b busy=%b expected 0000 1111 1", valid_vec, DACK, busy); end
    step(1);
    checks++; if (valid_vec !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fixed_gap: got valid=%b busy=%b expected 0000 0", valid_vec, busy); end
    step(1);
    checks++; if (valid_vec !== 4'b1000 || activeCh !== 2'd3) begin errors++; $display("FAIL fixed_next_ch3: got valid=%b ch=%0d expected 1000 3", valid_vec, activeCh); end
    go_quiet();
  endtask

  task automatic test_rotating();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    rotPriority = 1'b1;
    DREQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(6 + XLAT, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rot_grant_timeout: got no grant expected ch%0d", exp_order[g]);
      end else if (valid_vec !== (4'b0001 << exp_order[g]) || activeCh !== 2'(exp_order[g])) begin
        errors++; $display("FAIL rot_order: got valid=%b ch=%0d expected ch%0d", valid_vec, activeCh, exp_order[g]);
      end
      validDACK = 1'b1;
      step(1);
      validDACK = 1'b0;
      step(2);
    end
    rotPriority = 1'b0;
    go_quiet();
  endtask

  task automatic test_mask_swreq();
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    step(3 + XLAT);
    checks++; if (valid_vec !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mask_block: got valid=%b busy=%b expected 0000 0", valid_vec, busy); end
    swReq = 4'b0001;
    step(1);
    checks++; if (valid_vec !== 4'b0001 || activeCh !== 2'd0) begin errors++; $display("FAIL swreq_grant: got valid=%b ch=%0d expected 0001 0", valid_vec, activeCh); end
    validDACK = 1'b1;
    step(1);
    validDACK = 1'b0;
    step(1);
    checks++; if (swReqClr !== 4'b0001) begin errors++; $display("FAIL swreqclr_pulse: got %b expected 0001", swReqClr); end
    swReq = 4'b0000;
    step(1);
    checks++; if (swReqClr !== 4'b0000) begin errors++; $display("FAIL swreqclr_one_cycle: got %b expected 0000", swReqClr); end
    maskReg = 4'b0000;
    go_quiet();
  endtask

  task automatic test_pend_drop();
    hrq = 1'b0;
    DREQ = 4'b0100;
    step(1 + XLAT);
    checks++; if (valid_vec !== 4'b0100) begin errors++; $display("FAIL pend_grant: got %b expected 0100", valid_vec); end
    DREQ = 4'b0000;
    step(1 + XLAT);
    checks++; if (valid_vec !== 4'b0000 || busy !== 1'b0 || DACK !== 4'hF) begin errors++; $display("FAIL pend_drop: got valid=%b busy=%b dack=%b expected 0000 0 1111", valid_vec, busy, DACK); end
    step(2);
    DREQ = 4'b0100;
    step(1 + XLAT);
    checks++; if (valid_vec !== 4'b0100) begin errors++; $display("FAIL pend_hrq_grant: got %b expected 0100", valid_vec); end
    hrq = 1'b1;
    DREQ = 4'b0000;
    step(4 + XLAT);
    checks++; if (valid_vec !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL pend_hrq_hold: got valid=%b busy=%b expected 0100 1", valid_vec, busy); end
    validDACK = 1'b1;
    step(1);
    checks++; if (DACK !== 4'b1011) begin errors++; $display("FAIL pend_hrq_dack: got %b expected 1011", DACK); end
    validDACK = 1'b0;
    hrq = 1'b0;
    step(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_hrq_idle: got busy=%b expected 0", busy); end
    go_quiet();
  endtask

  task automatic test_reset_mid_serv();
    bit ok;
    rotPriority = 1'b1;
    DREQ = 4'b0100;
    wait_grant(6 + XLAT, ok);
    checks++; if (!ok || activeCh !== 2'd2) begin errors++; $display("FAIL rst_pre_grant: got ok=%0d ch=%0d expected 1 2", ok, activeCh); end
    DREQ = 4'b0010;
    validDACK = 1'b1;
    step(1);
    validDACK = 1'b0;
    step(2);
    // Pointer is now 3: order 3,0,1,2, so ch1 wins.
    wait_grant(6 + XLAT, ok);
    checks++; if (!ok || activeCh !== 2'd1) begin errors++; $display("FAIL rst_wrap_grant: got ok=%0d ch=%0d expected 1 1", ok, activeCh); end
    validDACK = 1'b1;
    step(2);
    checks++; if (DACK !== 4'b1101) begin errors++; $display("FAIL rst_serv_dack: got %b expected 1101", DACK); end
    RESET = 1'b1;
    step(1);
    checks++; if (valid_vec !== 4'b0000 || DACK !== 4'hF || activeCh !== 2'd0 || busy !== 1'b0 || swReqClr !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_serv: got valid=%b dack=%b ch=%0d busy=%b clr=%b expected 0000 1111 0 0 0000", valid_vec, DACK, activeCh, busy, swReqClr);
    end
    RESET = 1'b0;
    validDACK = 1'b0;
    DREQ = 4'b1111;
    wait_grant(6 + XLAT, ok);
    checks++; if (!ok || activeCh !== 2'd0) begin errors++; $display("FAIL rst_top_cleared: got ok=%0d ch=%0d expected 1 0", ok, activeCh); end
    rotPriority = 1'b0;
    go_quiet();
  endtask

  task automatic test_polarity();
    ctrlDisable = 1'b1;
    dreqSenseLow = 1'b1;
    dackSenseHigh = 1'b1;
    DREQ = 4'b1011;
    step(3 + XLAT);
    checks++; if (DACK !== 4'b0000) begin errors++; $display("FAIL pol_idle_dack: got %b expected 0000", DACK); end
    ctrlDisable = 1'b0;
    step(1);
    checks++; if (valid_vec !== 4'b0100 || activeCh !== 2'd2) begin errors++; $display("FAIL pol_grant: got valid=%b ch=%0d expected 0100 2", valid_vec, activeCh); end
    validDACK = 1'b1;
    step(1);
    checks++; if (DACK !== 4'b0100) begin errors++; $display("FAIL pol_dack: got %b expected 0100", DACK); end
    validDACK = 1'b0;
    step(2);
    go_quiet();
    ctrlDisable = 1'b1;
    dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b0;
    DREQ = 4'b0000;
    step(3 + XLAT);
    ctrlDisable = 1'b0;
  endtask

  task automatic test_ctrl_disable();
    bit ok;
    DREQ = 4'b0001;
    wait_grant(6 + XLAT, ok);
    checks++; if (!ok || activeCh !== 2'd0) begin errors++; $display("FAIL dis_grant: got ok=%0d ch=%0d expected 1 0", ok, activeCh); end
    validDACK = 1'b1;
    step(1);
    ctrlDisable = 1'b1;
    step(1);
    checks++; if (DACK !== 4'b1110) begin errors++; $display("FAIL dis_serv_continues: got %b expected 1110", DACK); end
    validDACK = 1'b0;
    step(6);
    checks++; if (busy !== 1'b0 || valid_vec !== 4'b0000) begin errors++; $display("FAIL dis_no_regrant: got busy=%b valid=%b expected 0 0000", busy, valid_vec); end
    go_quiet();
  endtask

  task automatic test_idle_validdack();
    validDACK = 1'b1;
    step(3);
    checks++; if (busy !== 1'b0 || DACK !== 4'hF) begin errors++; $display("FAIL idle_validdack: got busy=%b dack=%b expected 0 1111", busy, DACK); end
    validDACK = 1'b0;
    step(1);
  endtask

  task automatic test_random();
    logic [3:0] r, m, s, exp_req, oh, exp_dack, exp_clr;
    logic sl, sh, rp;
    int w, ptr;
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    model_top = 0;
    for (int it = 0; it < 40; it++) begin
      r  = 4'($urandom);
      m  = 4'($urandom);
      s  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      sl = 1'($urandom);
      sh = 1'($urandom);
      rp = 1'($urandom);
      ctrlDisable = 1'b1;
      DREQ = r; maskReg = m; swReq = s; dreqSenseLow = sl; dackSenseHigh = sh;
      rotPriority = rp; validDACK = 1'b0; hrq = 1'b0;
      step(3 + XLAT);
      if (!rp) model_top = 0;
      exp_req = model_req(r, m, s, 1'b0, sl);
      ptr = rp ? model_top : 0;
      w = model_winner(exp_req, ptr);
      ctrlDisable = 1'b0;
      step(1);
      if (w < 0) begin
        checks++; if (valid_vec !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rand_nogrant it=%0d: got valid=%b busy=%b expected 0000 0", it, valid_vec, busy); end
        ctrlDisable = 1'b1;
        step(1);
      end else begin
        oh = 4'b0001 << w;
        checks++; if (valid_vec !== oh || activeCh !== 2'(w)) begin errors++; $display("FAIL rand_grant it=%0d: got valid=%b ch=%0d expected %b %0d", it, valid_vec, activeCh, oh, w); end
        validDACK = 1'b1;
        ctrlDisable = 1'b1;
        step(1);
        exp_dack = sh ? oh : ~oh;
        checks++; if (DACK !== exp_dack) begin errors++; $display("FAIL rand_dack it=%0d: got %b expected %b", it, DACK, exp_dack); end
        validDACK = 1'b0;
        step(1);
        exp_clr = s[w] ? oh : 4'b0000;
        checks++; if (swReqClr !== exp_clr) begin errors++; $display("FAIL rand_swreqclr it=%0d: got %b expected %b", it, swReqClr, exp_clr); end
        step(1);
        model_top = rp ? (w + 1) % 4 : 0;
      end
    end
    ctrlDisable = 1'b1;
    swReq = 4'b0000; maskReg = 4'b0000; rotPriority = 1'b0;
    dreqSenseLow = 1'b0; dackSenseHigh = 1'b0; DREQ = 4'b0000;
    step(3 + XLAT);
    ctrlDisable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_mask_swreq();
    test_pend_drop();
    test_reset_mid_serv();
    test_polarity();
    test_ctrl_disable();
    test_idle_validdack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
